// File: rtl/rpn_eval_if.sv
// Character-stream bundle for rpn_eval: postfix input from the converter,
// decimal result output to the sink, plus BUSY/ERR status.
interface rpn_eval_if;
  logic       IN_STB;
  logic [7:0] IN_CHAR;
  logic       IN_ACK;
  logic       OUT_STB;
  logic [7:0] OUT_CHAR;
  logic       OUT_ACK;
  logic       BUSY;
  logic       ERR;

  modport master (
    output IN_STB, IN_CHAR, OUT_ACK,
    input  IN_ACK, OUT_STB, OUT_CHAR, BUSY, ERR
  );

  modport slave (
    input  IN_STB, IN_CHAR, OUT_ACK,
    output IN_ACK, OUT_STB, OUT_CHAR, BUSY, ERR
  );
endinterface

// File: rtl/rpn_eval.sv
// Postfix (RPN) evaluator with a shared restoring divider for '/' and decimal conversion.
// Optional macro RPN_ERR_EN: an erroneous expression prints "E\n" instead of a number.
module rpn_eval #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int NDIG  = 5
) (
  input  logic      CLK,
  input  logic      RST,
  rpn_eval_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(WIDTH);
  localparam int DW  = $clog2(NDIG);

  typedef enum logic [2:0] {
    IDLE, EXEC, DIV, CONV, EMIT_SIGN, EMIT_DIG, EMIT_LF
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [SPW-1:0]   sp;
  logic [7:0]       op;
  logic             in_ack;
  logic             out_stb;
  logic [7:0]       out_char;
  logic             err;
  logic             neg;
  logic             q_neg;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_d;
  logic [CW-1:0]    cnt;
  logic [3:0]       digits [NDIG];
  logic [DW-1:0]    ndig;
  logic [DW-1:0]    idx;
`ifdef RPN_ERR_EN
  logic             show_err;
`endif

  logic             has_a;
  logic             has_b;
  logic [AW-1:0]    a_idx;
  logic [AW-1:0]    b_idx;
  logic [SPW-1:0]   base;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu;
  logic             eq_err;
  logic             in_digit;
  logic             in_cmd;
  logic [WIDTH:0]   trial;
  logic             sub_ok;
  logic [WIDTH-1:0] next_r;
  logic [WIDTH-1:0] next_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  // Operand fetch substitutes 0 for missing entries; base is the slot the result lands in.
  always_comb begin
    has_b  = sp != '0;
    has_a  = sp > SPW'(1);
    b_idx  = AW'(sp - SPW'(1));
    a_idx  = AW'(sp - SPW'(2));
    b      = has_b ? stack[b_idx] : '0;
    a      = has_a ? stack[a_idx] : '0;
    base   = has_a ? sp - SPW'(2) : '0;
    eq_err = err | ~has_b;
    if (op == 8'h2B)      alu = a + b;
    else if (op == 8'h2D) alu = a - b;
    else                  alu = a * b;
    in_digit = (bus.IN_CHAR >= 8'h30) && (bus.IN_CHAR <= 8'h39);
    in_cmd   = in_digit || (bus.IN_CHAR == 8'h2B) || (bus.IN_CHAR == 8'h2D) ||
               (bus.IN_CHAR == 8'h2A) || (bus.IN_CHAR == 8'h2F) || (bus.IN_CHAR == 8'h3D);
  end

  // One restoring-division step; div_q shifts the dividend out and the quotient in.
  always_comb begin
    trial  = {div_r, div_q[WIDTH-1]};
    sub_ok = trial >= {1'b0, div_d};
    next_r = sub_ok ? trial[WIDTH-1:0] - div_d : trial[WIDTH-1:0];
    next_q = {div_q[WIDTH-2:0], sub_ok};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      sp       <= '0;
      op       <= '0;
      in_ack   <= 1'b0;
      out_stb  <= 1'b0;
      out_char <= 8'h00;
      err      <= 1'b0;
      neg      <= 1'b0;
      q_neg    <= 1'b0;
      div_q    <= '0;
      div_r    <= '0;
      div_d    <= '0;
      cnt      <= '0;
      ndig     <= '0;
      idx      <= '0;
`ifdef RPN_ERR_EN
      show_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          in_ack <= 1'b1;
          if (bus.IN_STB && in_ack && in_cmd) begin
            op     <= bus.IN_CHAR;
            in_ack <= 1'b0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          state  <= IDLE;
          in_ack <= 1'b1;
          if (op >= 8'h30 && op <= 8'h39) begin
            if (sp == SPW'(DEPTH)) err <= 1'b1;
            else begin
              stack[sp[AW-1:0]] <= {{(WIDTH-4){1'b0}}, op[3:0]};
              sp <= sp + SPW'(1);
            end
          end else if (op == 8'h3D) begin
            sp     <= '0;
            in_ack <= 1'b0;
            err    <= eq_err;
            neg    <= b[WIDTH-1];
            div_q  <= mag(b);
            div_r  <= '0;
            div_d  <= WIDTH'(10);
            cnt    <= '0;
            ndig   <= '0;
            state  <= CONV;
`ifdef RPN_ERR_EN
            if (eq_err) begin
              show_err <= 1'b1;
              out_stb  <= 1'b1;
              out_char <= 8'h45;
              state    <= EMIT_SIGN;
            end
`endif
          end else if (op == 8'h2F) begin
            if (!has_a) err <= 1'b1;
            if (b == '0) begin
              stack[base[AW-1:0]] <= '0;
              sp  <= base + SPW'(1);
              err <= 1'b1;
            end else begin
              div_q  <= mag(a);
              div_r  <= '0;
              div_d  <= mag(b);
              q_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
              cnt    <= '0;
              sp     <= base;
              in_ack <= 1'b0;
              state  <= DIV;
            end
          end else begin
            if (!has_a) err <= 1'b1;
            stack[base[AW-1:0]] <= alu;
            sp <= base + SPW'(1);
          end
        end
        DIV: begin
          div_q <= next_q;
          div_r <= next_r;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            stack[sp[AW-1:0]] <= q_neg ? -next_q : next_q;
            sp     <= sp + SPW'(1);
            in_ack <= 1'b1;
            state  <= IDLE;
          end
        end
        // Each pass through the divider yields the next digit, least significant first.
        CONV: begin
          div_q <= next_q;
          div_r <= next_r;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            digits[ndig] <= next_r[3:0];
            div_r        <= '0;
            if (next_q == '0) begin
              idx     <= ndig;
              out_stb <= 1'b1;
              if (neg) begin
                out_char <= 8'h2D;
                state    <= EMIT_SIGN;
              end else begin
                out_char <= ascii(next_r[3:0]);
                state    <= EMIT_DIG;
              end
            end else begin
              ndig <= ndig + DW'(1);
            end
          end
        end
        EMIT_SIGN: begin
          if (bus.OUT_ACK) begin
`ifdef RPN_ERR_EN
            if (show_err) begin
              out_char <= 8'h0A;
              state    <= EMIT_LF;
            end else
`endif
            begin
              out_char <= ascii(digits[idx]);
              state    <= EMIT_DIG;
            end
          end
        end
        EMIT_DIG: begin
          if (bus.OUT_ACK) begin
            if (idx == '0) begin
              out_char <= 8'h0A;
              state    <= EMIT_LF;
            end else begin
              idx      <= idx - DW'(1);
              out_char <= ascii(digits[idx - DW'(1)]);
            end
          end
        end
        EMIT_LF: begin
          if (bus.OUT_ACK) begin
            out_stb  <= 1'b0;
            out_char <= 8'h00;
            err      <= 1'b0;
`ifdef RPN_ERR_EN
            show_err <= 1'b0;
`endif
            in_ack   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IN_ACK   = in_ack;
  assign bus.OUT_STB  = out_stb;
  assign bus.OUT_CHAR = out_char;
  assign bus.BUSY     = state != IDLE;
  assign bus.ERR      = err;
endmodule
